tt_um_stepper: RTL and testbench
================================

Name: tt_um_stepper

Overview:
Tiny Tapeout top-level stepper-motor sequencer. It generates 4-phase coil drive patterns (wave, full-step, half-step) at a programmable step rate and direction, with a step strobe and status on the dedicated outputs. An 8-bit wrapping position counter is driven on the bidirectional pins.

Parameters:
PRESCALE, 16, clk cycles per base tick (must be >= 2)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-high (asserted when 1 despite the name); sampled on clk rising edge
ena  input  1  design-selected flag; ignored
ui_in  input  8  [0] enable, [1] dir (0=fwd, 1=rev), [3:2] mode, [7:4] speed
uo_out  output  8  [3:0] coils {A,B,A',B'} = {bit3..bit0}, [4] step pulse, [5] dir echo, [6] moving, [7] enable echo
uio_in  input  8  unused
uio_out  output  8  position counter
uio_oe  output  8  constant 8'hFF

Behaviour:
- State: 3-bit phase idx, 8-bit pos, prescaler pre (0..PRESCALE-1), 4-bit interval counter iv, 1-bit step_q.
- Reset (rst_n=1 at clk edge): phase=0, pos=0, pre=0, iv=0, step_q=0.
- Half-step table, idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Modes:
  - 00 wave: even idx only.
  - 01 full: odd idx only.
  - 10 half: all idx.
  - 11 brake: no stepping; pattern held.
- run = enable & (speed!=0) & (mode!=11). If run=0: pre and iv cleared and held; no steps.
- Tick: pre==PRESCALE-1 with run=1. pre then wraps to 0; otherwise pre increments.
- On a tick:
  - If iv >= 15-speed: step; iv<=0.
  - Else iv<=iv+1.
  - Step interval = (16-speed)*PRESCALE cycles.
  - Speed change takes effect immediately (>= compare).
- Step amount:
  - half: ±1.
  - wave/full: ±2 if idx parity already matches the mode, else ±1 (parity correction).
  - dir=0 adds, dir=1 subtracts, modulo 8.
- pos: +1 per forward step, -1 per reverse step, wraps 255<->0.
- step_q=1 for exactly the one cycle following the step edge (same cycle phase/pos show new values), else 0.
- Coil output, combinational: uo_out[3:0] = enable ? table[phase] : 0000. In brake mode the table[phase] pattern stays energized.
- uo_out[5]=ui_in[1]; uo_out[6]=run; uo_out[7]=ui_in[0]. All combinational.
- uio_out=pos; uio_oe=8'hFF.
- Reset mid-operation overrides everything. Outputs reflect reset state on the cycle after the reset edge; coils follow enable and phase 0.
- Simultaneous dir/mode change and step: values sampled on that same edge are used.

Optional Feature:
- STEPPER_POS_EN defined: position counter present; uio_out=pos, uio_oe=8'hFF.
- STEPPER_POS_EN undefined: pos register removed; uio_out=8'h00, uio_oe=8'h00. Everything else unchanged.

Test Plan:
- Reset, then ui_in=8'h00 for 100 cycles -> uo_out=8'h00, uio_out=0, uio_oe=8'hFF.
- Enable, half mode, fwd, speed=15 (ui_in=8'hF9):
  - first step pulse 16 cycles after release.
  - coils step 1000->1100->0100->…->1001->1000, one step per 16 cycles.
  - uio_out counts 1,2,…
- Full mode, speed=14 (ui_in=8'hE5) from phase 0:
  - first step corrects to idx1 (1100) after 32 cycles.
  - subsequent steps 0110, 0011, 1001 every 32 cycles.
- Wave mode, reverse (ui_in=8'hF3) from pos=0 -> coils 1000->0001->0010; uio_out 0->255->254 (wrap).
- Brake (ui_in=8'hFD) -> coils hold the current pattern; no step pulses for 1000 cycles; uo_out[6]=0.
- Drop enable mid-run -> coils 0000 immediately. Re-enable -> first step after a full interval. Assert rst_n mid-run -> phase/pos=0 next cycle.

Source files
------------

// File: rtl/tt_um_stepper.sv
// -----------------------------------------------------------------------------
// tt_um_stepper
//   Tiny Tapeout stepper-motor sequencer. Produces 4-phase coil patterns
//   (wave / full-step / half-step) at a programmable rate and direction, with
//   a one-cycle step strobe and status echoes on the dedicated outputs.
//
//   Optional feature macro: STEPPER_POS_EN
//     defined   : 8-bit wrapping position counter driven on uio_out, uio_oe=FF
//     undefined : no position register, uio_out=00, uio_oe=00
//
// Parameters
//   PRESCALE : clk cycles per base tick (>= 2)
//
// Ports
//   clk      : system clock
//   rst_n    : synchronous reset, ACTIVE-HIGH despite the name
//   ena      : design-selected flag (ignored)
//   ui_in    : [0] enable, [1] dir (0 fwd / 1 rev), [3:2] mode, [7:4] speed
//   uo_out   : [3:0] coils {A,B,A',B'}, [4] step strobe, [5] dir echo,
//              [6] moving, [7] enable echo
//   uio_in   : unused
//   uio_out  : position counter (or 0 without STEPPER_POS_EN)
//   uio_oe   : FF with STEPPER_POS_EN, else 00
// -----------------------------------------------------------------------------
module tt_um_stepper #(
   parameter int PRESCALE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int            PW       = $clog2(PRESCALE);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      MODE_WAVE  = 2'b00,
      MODE_FULL  = 2'b01,
      MODE_HALF  = 2'b10,
      MODE_BRAKE = 2'b11
   } mode_t;

   logic          w_enable;
   logic          w_dir;
   mode_t         w_mode;
   logic [3:0]    w_speed;
   logic          w_run;
   logic          w_tick;
   logic          w_step;
   logic [2:0]    w_delta;
   logic [2:0]    w_phase_nxt;
   logic [3:0]    w_coils;
   logic          w_unused;

   logic [2:0]    r_phase;
   logic [PW-1:0] r_pre;
   logic [3:0]    r_iv;
   logic          r_step_q;

   assign w_enable = ui_in[0];
   assign w_dir    = ui_in[1];
   assign w_mode   = mode_t'(ui_in[3:2]);
   assign w_speed  = ui_in[7:4];

   assign w_run  = w_enable && (w_speed != 4'd0) && (w_mode != MODE_BRAKE);
   assign w_tick = w_run && (r_pre == PRE_LAST);
   // ">=" rather than "==" so lowering the interval mid-count steps at once
   assign w_step = w_tick && (r_iv >= (4'd15 - w_speed));

   assign w_unused = &{1'b0, ena, uio_in};

   // Wave/full move two indices when already on their parity, one otherwise,
   // so a mode switch lands on the nearest valid index in the travel direction.
   always_comb begin
      w_delta = 3'd1;
      case (w_mode)
         MODE_WAVE: w_delta = r_phase[0] ? 3'd1 : 3'd2;
         MODE_FULL: w_delta = r_phase[0] ? 3'd2 : 3'd1;
         default:   w_delta = 3'd1;
      endcase
      w_phase_nxt = w_dir ? (r_phase - w_delta) : (r_phase + w_delta);
   end

   always_comb begin
      w_coils = 4'b1000;
      case (r_phase)
         3'd0:    w_coils = 4'b1000;
         3'd1:    w_coils = 4'b1100;
         3'd2:    w_coils = 4'b0100;
         3'd3:    w_coils = 4'b0110;
         3'd4:    w_coils = 4'b0010;
         3'd5:    w_coils = 4'b0011;
         3'd6:    w_coils = 4'b0001;
         default: w_coils = 4'b1001;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_phase  <= '0;
         r_pre    <= '0;
         r_iv     <= '0;
         r_step_q <= 1'b0;
      end else begin
         r_step_q <= w_step;
         if (!w_run) begin
            r_pre <= '0;
            r_iv  <= '0;
         end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
               r_iv <= w_step ? '0 : r_iv + 4'd1;
            end
            if (w_step) begin
               r_phase <= w_phase_nxt;
            end
         end
      end
   end

   assign uo_out = {w_enable, w_run, w_dir, r_step_q,
                    (w_enable ? w_coils : 4'b0000)};

`ifdef STEPPER_POS_EN
   logic [7:0] r_pos;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_pos <= '0;
      end else if (w_step) begin
         r_pos <= w_dir ? (r_pos - 8'd1) : (r_pos + 8'd1);
      end
   end

   assign uio_out = r_pos;
   assign uio_oe  = '1;
`else
   assign uio_out = '0;
   assign uio_oe  = '0;
`endif

endmodule

// File: tb/tb_tt_um_stepper.sv
// -----------------------------------------------------------------------------
// tb_tt_um_stepper
//   Self-checking bench for tt_um_stepper: directed scenarios with literal
//   expectations, followed by randomized ui_in/reset traffic compared against
//   a behavioural model (step counting in ticks, nearest-valid-index search).
//   Honours STEPPER_POS_EN for the uio_* expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tt_um_stepper;

   localparam int PRESCALE = 16;
`ifdef STEPPER_POS_EN
   localparam bit POS_EN = 1'b1;
`else
   localparam bit POS_EN = 1'b0;
`endif

   localparam logic [3:0] TBL [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                      4'b0010, 4'b0011, 4'b0001, 4'b1001};

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b1;
   logic       ena    = 1'b1;
   logic [7:0] ui_in  = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   tt_um_stepper #(.PRESCALE(PRESCALE)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   int m_phase = 0;
   int m_pos   = 0;
   int m_cyc   = 0;   // cycles into the current base tick
   int m_ticks = 0;   // base ticks since the last step
   bit m_step  = 1'b0;

   function automatic bit idx_ok(int mode, int p);
      return (mode == 2) || (mode == 0 && (p % 2) == 0) || (mode == 1 && (p % 2) == 1);
   endfunction

   always @(posedge clk) begin : ref_model
      int en, dir, mode, spd, d;
      bit run;
      en   = int'(ui_in[0]);
      dir  = int'(ui_in[1]);
      mode = int'(ui_in[3:2]);
      spd  = int'(ui_in[7:4]);
      run  = (en == 1) && (spd != 0) && (mode != 3);
      if (rst_n) begin
         m_phase = 0; m_pos = 0; m_cyc = 0; m_ticks = 0; m_step = 1'b0;
      end else begin
         m_step = 1'b0;
         if (!run) begin
            m_cyc = 0; m_ticks = 0;
         end else begin
            m_cyc++;
            if (m_cyc == PRESCALE) begin
               m_cyc = 0;
               m_ticks++;
               // one step every (16-speed) ticks, judged with the current speed
               if (m_ticks >= 16 - spd) begin
                  m_ticks = 0;
                  m_step  = 1'b1;
                  d = (dir == 1) ? 7 : 1;
                  m_phase = (m_phase + d) % 8;
                  if (!idx_ok(mode, m_phase)) m_phase = (m_phase + d) % 8;
                  m_pos = (m_pos + ((dir == 1) ? 255 : 1)) % 256;
               end
            end
         end
      end
   end

   function automatic logic [7:0] exp_uo();
      logic en, run;
      logic [3:0] coil;
      en   = ui_in[0];
      run  = en && (ui_in[7:4] != 4'd0) && (ui_in[3:2] != 2'b11);
      coil = en ? TBL[m_phase] : 4'b0000;
      return {en, run, ui_in[1], m_step, coil};
   endfunction

   function automatic logic [7:0] exp_pos(int p);
      return POS_EN ? 8'(p) : 8'h00;
   endfunction

   function automatic logic [7:0] exp_oe();
      return POS_EN ? 8'hFF : 8'h00;
   endfunction

   // Hold reset two cycles with ui_in applied, release on a falling edge.
   task automatic do_reset(input logic [7:0] v);
      @(negedge clk);
      rst_n = 1'b1;
      ui_in = v;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      ui_in = 8'h00;
      repeat (2) @(negedge clk);
      n_vec++; if (uo_out !== 8'h00) begin n_bad++; $display("FAIL reset_uo got %h expected 00", uo_out); end
      n_vec++; if (uio_out !== 8'h00) begin n_bad++; $display("FAIL reset_pos got %h expected 00", uio_out); end
      n_vec++; if (uio_oe !== exp_oe()) begin n_bad++; $display("FAIL reset_oe got %h expected %h", uio_oe, exp_oe()); end
      rst_n = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (c % 10 == 0) begin
            n_vec++;
            if ({uo_out, uio_out} !== 16'h0000) begin
               n_bad++; $display("FAIL idle c=%0d got %h/%h expected 00/00", c, uo_out, uio_out);
            end
         end
      end
   endtask

   task automatic test_half();
      do_reset(8'hF9);
      for (int c = 1; c <= 16 * 9; c++) begin
         int k;
         k = c / 16;
         @(negedge clk);
         n_vec++; if (uo_out[4] !== (c % 16 == 0)) begin n_bad++; $display("FAIL half_pulse c=%0d got %b", c, uo_out[4]); end
         n_vec++; if (uo_out[3:0] !== TBL[k % 8]) begin n_bad++; $display("FAIL half_coils c=%0d got %b expected %b", c, uo_out[3:0], TBL[k % 8]); end
         n_vec++; if (uio_out !== exp_pos(k)) begin n_bad++; $display("FAIL half_pos c=%0d got %0d expected %0d", c, uio_out, exp_pos(k)); end
         n_vec++; if (uo_out[7:5] !== 3'b110) begin n_bad++; $display("FAIL half_status c=%0d got %b expected 110", c, uo_out[7:5]); end
      end
   endtask

   task automatic test_full();
      logic [3:0] seq [4];
      logic [3:0] e;
      seq = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
      do_reset(8'hE5);
      for (int c = 1; c <= 32 * 5; c++) begin
         int k;
         k = c / 32;
         e = (k == 0) ? 4'b1000 : seq[(k - 1) % 4];
         @(negedge clk);
         n_vec++; if (uo_out[4] !== (c % 32 == 0)) begin n_bad++; $display("FAIL full_pulse c=%0d got %b", c, uo_out[4]); end
         n_vec++; if (uo_out[3:0] !== e) begin n_bad++; $display("FAIL full_coils c=%0d got %b expected %b", c, uo_out[3:0], e); end
         n_vec++; if (uio_out !== exp_pos(k)) begin n_bad++; $display("FAIL full_pos c=%0d got %0d expected %0d", c, uio_out, exp_pos(k)); end
      end
   endtask

   task automatic test_wave_rev();
      logic [3:0] seq [4];
      seq = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
      do_reset(8'hF3);
      for (int c = 1; c <= 16 * 4; c++) begin
         int k;
         k = c / 16;
         @(negedge clk);
         n_vec++; if (uo_out[3:0] !== seq[k % 4]) begin n_bad++; $display("FAIL wave_coils c=%0d got %b expected %b", c, uo_out[3:0], seq[k % 4]); end
         n_vec++; if (uio_out !== exp_pos((256 - k) % 256)) begin n_bad++; $display("FAIL wave_pos c=%0d got %0d expected %0d", c, uio_out, exp_pos((256 - k) % 256)); end
         n_vec++; if (uo_out[5] !== 1'b1) begin n_bad++; $display("FAIL wave_dir c=%0d got %b expected 1", c, uo_out[5]); end
      end
   endtask

   task automatic test_brake();
      do_reset(8'hF9);
      repeat (16 * 3 + 5) @(negedge clk);
      ui_in = 8'hFD;
      for (int c = 1; c <= 1000; c++) begin
         @(negedge clk);
         n_vec++; if (uo_out !== 8'h86) begin n_bad++; $display("FAIL brake_uo c=%0d got %h expected 86", c, uo_out); end
         n_vec++; if (uio_out !== exp_pos(3)) begin n_bad++; $display("FAIL brake_pos c=%0d got %0d expected %0d", c, uio_out, exp_pos(3)); end
      end
   endtask

   task automatic test_enable_drop();
      logic [3:0] e;
      do_reset(8'hF9);
      repeat (40) @(negedge clk);
      ui_in = 8'hF8;
      #1;
      n_vec++; if (uo_out !== 8'h00) begin n_bad++; $display("FAIL drop_immediate got %h expected 00", uo_out); end
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         n_vec++; if (uo_out !== 8'h00) begin n_bad++; $display("FAIL drop_hold c=%0d got %h expected 00", c, uo_out); end
         n_vec++; if (uio_out !== exp_pos(2)) begin n_bad++; $display("FAIL drop_pos c=%0d got %0d expected %0d", c, uio_out, exp_pos(2)); end
      end
      ui_in = 8'hF9;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         e = (c == 16) ? 4'b0110 : 4'b0100;
         n_vec++; if (uo_out[4] !== (c == 16)) begin n_bad++; $display("FAIL reenable_pulse c=%0d got %b", c, uo_out[4]); end
         n_vec++; if (uo_out[3:0] !== e) begin n_bad++; $display("FAIL reenable_coils c=%0d got %b expected %b", c, uo_out[3:0], e); end
      end
      n_vec++; if (uio_out !== exp_pos(3)) begin n_bad++; $display("FAIL reenable_pos got %0d expected %0d", uio_out, exp_pos(3)); end
   endtask

   task automatic test_reset_mid();
      do_reset(8'hF9);
      repeat (40) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (uo_out !== 8'hC8) begin n_bad++; $display("FAIL midreset_uo got %h expected c8", uo_out); end
      n_vec++; if (uio_out !== 8'h00) begin n_bad++; $display("FAIL midreset_pos got %h expected 00", uio_out); end
      rst_n = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         n_vec++; if (uo_out[4] !== (c == 16)) begin n_bad++; $display("FAIL midreset_pulse c=%0d got %b", c, uo_out[4]); end
      end
   endtask

   task automatic test_random();
      int hold;
      logic [7:0] v;
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         n_vec++; if (uo_out !== exp_uo()) begin n_bad++; $display("FAIL rand_uo c=%0d ui=%h got %h expected %h", c, ui_in, uo_out, exp_uo()); end
         n_vec++; if (uio_out !== exp_pos(m_pos)) begin n_bad++; $display("FAIL rand_pos c=%0d got %0d expected %0d", c, uio_out, exp_pos(m_pos)); end
         n_vec++; if (uio_oe !== exp_oe()) begin n_bad++; $display("FAIL rand_oe c=%0d got %h expected %h", c, uio_oe, exp_oe()); end
         if (hold == 0) begin
            v = 8'($urandom);
            v[0] = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) v[7:4] = 4'($urandom_range(12, 15));
            ui_in = v;
            rst_n = ($urandom_range(0, 40) == 0);
            hold  = int'($urandom_range(1, 80));
         end else begin
            rst_n = 1'b0;
            hold--;
         end
      end
      rst_n = 1'b0;
   endtask

   initial begin
      test_reset();
      test_half();
      test_full();
      test_wave_rev();
      test_brake();
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
